// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ register-write requesters into a
// single one-hot write port, flagging out-of-range addresses and counting writes.
module reg_bank_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REGS-1:0]            reg_write,
  output logic [DATA_WIDTH-1:0]          reg_data,
  output logic                           err_addr,
  output logic [15:0]                    wr_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_next;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [NUM_REGS-1:0]   write_vec;
  logic                  addr_ok;

  // Two passes give the rotated search: first ptr..top, then wrap to 0..ptr-1.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && req_valid[j] && (j >= int'(ptr))) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && req_valid[j] && (j < int'(ptr))) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
    if (rst) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_any && (j == int'(grant_idx))) begin
        req_ready[j] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    grant_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j == int'(grant_idx)) begin
        grant_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        grant_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    write_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      write_vec[r] = (int'(grant_addr) == r);
    end
    addr_ok  = (int'(grant_addr) < NUM_REGS);
    ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // The counter follows the registered strobe, so it lags reg_write by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      reg_write <= '0;
      reg_data  <= '0;
      err_addr  <= 1'b0;
      wr_count  <= '0;
    end else begin
      reg_write <= '0;
      if (grant_any) begin
        ptr <= ptr_next;
        if (addr_ok) begin
          reg_write <= write_vec;
          reg_data  <= grant_data;
        end else begin
          err_addr <= 1'b1;
        end
      end
      if (|reg_write) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: a directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a behavioural model.
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_addr;
  logic [63:0] req_data;

  logic [3:0]  ready8, ready6;
  logic [7:0]  rw8;
  logic [5:0]  rw6;
  logic [15:0] rd8, rd6;
  logic        err8, err6;
  logic [15:0] cnt8, cnt6;

  int errors = 0;
  int checks = 0;

  reg_bank_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .NUM_REGS(8), .ADDR_WIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(ready8), .reg_write(rw8), .reg_data(rd8), .err_addr(err8), .wr_count(cnt8)
  );

  reg_bank_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .NUM_REGS(6), .ADDR_WIDTH(3)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(ready6), .reg_write(rw6), .reg_data(rd6), .err_addr(err6), .wr_count(cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: index 0 mirrors the 8-register instance, index 1 the 6-register one.
  int          m_ptr = 0;
  logic        m_known = 1'b0;
  logic [7:0]  m_rw[2];
  logic [15:0] m_rd[2];
  logic        m_err[2];
  logic [15:0] m_cnt[2];
  int          m_nregs[2] = '{8, 6};

  function automatic int modelGrant();
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelStep();
    int g;
    int a;
    g = modelGrant();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_rw[d] = '0; m_rd[d] = '0; m_err[d] = 1'b0; m_cnt[d] = '0;
      end else begin
        if (m_rw[d] != 0) m_cnt[d] = m_cnt[d] + 16'd1;
        m_rw[d] = '0;
        if (g >= 0) begin
          a = int'(req_addr[g*3 +: 3]);
          if (a < m_nregs[d]) begin
            m_rw[d] = 8'(1 << a);
            m_rd[d] = req_data[g*16 +: 16];
          end else begin
            m_err[d] = 1'b1;
          end
        end
      end
    end
    if (rst) m_ptr = 0;
    else if (g >= 0) m_ptr = (g + 1) % 4;
    if (rst) m_known = 1'b1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int g;
    logic [3:0] exp_ready;
    g = modelGrant();
    exp_ready = (rst || g < 0) ? 4'h0 : 4'(1 << g);
    check("ready8", 16'(ready8), 16'(exp_ready));
    check("ready6", 16'(ready6), 16'(exp_ready));
    if (m_known) begin
      check("write8", 16'(rw8), 16'(m_rw[0]));
      check("data8",  rd8, m_rd[0]);
      check("err8",   16'(err8), 16'(m_err[0]));
      check("count8", cnt8, m_cnt[0]);
      check("write6", 16'(rw6), 16'(m_rw[1][5:0]));
      check("data6",  rd6, m_rd[1]);
      check("err6",   16'(err6), 16'(m_err[1]));
      check("count6", cnt6, m_cnt[1]);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [11:0] a,
                               input logic [63:0] d);
    rst = r; req_valid = v; req_addr = a; req_data = d;
    #1;
    checkOutput();
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [11:0] addr;
    logic [63:0] data;
    logic        chk;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_write;
    logic [15:0] exp_data;
    logic [15:0] exp_count;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [11:0] a,
                              input logic [63:0] d, input logic c, input logic [3:0] er,
                              input logic [7:0] ew, input logic [15:0] ed, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.valid = v; t.addr = a; t.data = d; t.chk = c;
    t.exp_ready = er; t.exp_write = ew; t.exp_data = ed; t.exp_count = ec;
    return t;
  endfunction

  localparam logic [11:0] A1 = {3'd4, 3'd3, 3'd2, 3'd5};
  localparam logic [63:0] D1 = {16'h1003, 16'h1002, 16'h1001, 16'hBEEF};
  localparam logic [11:0] A2 = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [63:0] D2 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

  vec_t vecs[25];

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;

    // Single write, full contention, pointer skip, then a reset landing mid-contention.
    vecs[0]  = mk(1, 4'h0, A1, D1, 0, 4'h0, 8'h00, 16'h0000, 16'd0);
    vecs[1]  = mk(1, 4'h1, A1, D1, 1, 4'h0, 8'h00, 16'h0000, 16'd0);
    vecs[2]  = mk(0, 4'h1, A1, D1, 1, 4'h1, 8'h00, 16'h0000, 16'd0);
    vecs[3]  = mk(0, 4'h0, A1, D1, 1, 4'h0, 8'h20, 16'hBEEF, 16'd0);
    vecs[4]  = mk(1, 4'h0, A1, D1, 1, 4'h0, 8'h00, 16'hBEEF, 16'd1);
    vecs[5]  = mk(0, 4'hF, A2, D2, 1, 4'h1, 8'h00, 16'h0000, 16'd0);
    vecs[6]  = mk(0, 4'hF, A2, D2, 1, 4'h2, 8'h02, 16'h1000, 16'd0);
    vecs[7]  = mk(0, 4'hF, A2, D2, 1, 4'h4, 8'h04, 16'h1001, 16'd1);
    vecs[8]  = mk(0, 4'hF, A2, D2, 1, 4'h8, 8'h08, 16'h1002, 16'd2);
    vecs[9]  = mk(0, 4'hF, A2, D2, 1, 4'h1, 8'h10, 16'h1003, 16'd3);
    vecs[10] = mk(0, 4'hF, A2, D2, 1, 4'h2, 8'h02, 16'h1000, 16'd4);
    vecs[11] = mk(0, 4'hF, A2, D2, 1, 4'h4, 8'h04, 16'h1001, 16'd5);
    vecs[12] = mk(0, 4'hF, A2, D2, 1, 4'h8, 8'h08, 16'h1002, 16'd6);
    vecs[13] = mk(0, 4'h0, A2, D2, 1, 4'h0, 8'h10, 16'h1003, 16'd7);
    vecs[14] = mk(0, 4'h0, A2, D2, 1, 4'h0, 8'h00, 16'h1003, 16'd8);
    vecs[15] = mk(0, 4'h2, A2, D2, 1, 4'h2, 8'h00, 16'h1003, 16'd8);
    vecs[16] = mk(0, 4'h3, A2, D2, 1, 4'h1, 8'h04, 16'h1001, 16'd8);
    vecs[17] = mk(0, 4'h3, A2, D2, 1, 4'h2, 8'h02, 16'h1000, 16'd9);
    vecs[18] = mk(0, 4'h0, A2, D2, 1, 4'h0, 8'h04, 16'h1001, 16'd10);
    vecs[19] = mk(0, 4'h0, A2, D2, 1, 4'h0, 8'h00, 16'h1001, 16'd11);
    vecs[20] = mk(0, 4'hF, A2, D2, 1, 4'h4, 8'h00, 16'h1001, 16'd11);
    vecs[21] = mk(1, 4'hF, A2, D2, 1, 4'h0, 8'h08, 16'h1002, 16'd11);
    vecs[22] = mk(0, 4'hF, A2, D2, 1, 4'h1, 8'h00, 16'h0000, 16'd0);
    vecs[23] = mk(0, 4'h0, A2, D2, 1, 4'h0, 8'h02, 16'h1000, 16'd0);
    vecs[24] = mk(0, 4'h0, A2, D2, 1, 4'h0, 8'h00, 16'h1000, 16'd1);

    @(negedge clk);
    for (int n = 0; n < 25; n++) begin
      applyStimulus(vecs[n].rst, vecs[n].valid, vecs[n].addr, vecs[n].data);
      check($sformatf("vec%0d_ready", n), 16'(ready8), 16'(vecs[n].exp_ready));
      if (vecs[n].chk) begin
        check($sformatf("vec%0d_write", n), 16'(rw8), 16'(vecs[n].exp_write));
        check($sformatf("vec%0d_data", n), rd8, vecs[n].exp_data);
        check($sformatf("vec%0d_count", n), cnt8, vecs[n].exp_count);
      end
      stepClock();
    end

    // Out-of-range address on the 6-register instance: handshake completes, no write, sticky error.
    applyStimulus(1, 4'h0, '0, '0);
    stepClock();
    applyStimulus(0, 4'h1, {9'd0, 3'd7}, {48'd0, 16'hAAAA});
    check("bad_ready6", 16'(ready6), 16'h0001);
    stepClock();
    applyStimulus(0, 4'h0, '0, '0);
    check("bad_write6", 16'(rw6), 16'h0000);
    check("bad_err6", 16'(err6), 16'h0001);
    check("bad_write8", 16'(rw8), 16'h0080);
    stepClock();
    applyStimulus(0, 4'h0, '0, '0);
    check("bad_err_hold", 16'(err6), 16'h0001);
    check("bad_count6", cnt6, 16'd0);
    check("bad_count8", cnt8, 16'd1);
    stepClock();

    // Counter wrap: preload 0xFFFF while a write strobe is pending.
    applyStimulus(0, 4'h1, {9'd0, 3'd3}, {48'd0, 16'h5555});
    stepClock();
    applyStimulus(0, 4'h0, '0, '0);
    force dut8.wr_count = 16'hFFFF;
    m_cnt[0] = 16'hFFFF;
    #1;
    release dut8.wr_count;
    stepClock();
    applyStimulus(0, 4'h0, '0, '0);
    check("wrap_count8", cnt8, 16'h0000);
    stepClock();

    // A lone continuously-valid requester is granted every cycle.
    for (int n = 0; n < 4; n++) begin
      applyStimulus(0, 4'h4, 12'($urandom), {$urandom, $urandom});
      check("single_ready", 16'(ready8), 16'h0004);
      stepClock();
    end

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                    12'($urandom), {$urandom, $urandom});
      stepClock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
